// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO for the UART data path: exact fill level, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags, registered or FWFT read.
module uart_fifo_param #(
    parameter int WIDTH    = 9,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter bit FWFT     = 1'b0
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [WIDTH-1:0]  DataIn,
    input  logic              Write,
    input  logic              Read,
    input  logic              ClearOV,
    output logic [WIDTH-1:0]  DataOut,
    output logic              Valid,
    output logic              Full,
    output logic              Empty,
    output logic              AlmostFull,
    output logic              AlmostEmpty,
    output logic              OV,
    output logic              UN,
    output logic [ADDR_W:0]   Count,
    output logic [ADDR_W-1:0] ReadPtr,
    output logic [ADDR_W-1:0] WritePtr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_L    = (ADDR_W + 1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W:0]  wptr_q, wptr_d;
    logic [ADDR_W:0]  rptr_q, rptr_d;
    logic             ov_q, ov_d;
    logic             un_q, un_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] head_word;
    logic [ADDR_W:0]  count;
    logic             rd_ok, wr_ok;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count       = wptr_q - rptr_q;
    assign Full        = (count == DEPTH_L);
    assign Empty       = (count == '0);
    assign AlmostFull  = (count >= AF_L);
    assign AlmostEmpty = (count <= AE_L);
    assign Count       = count;
    assign ReadPtr     = rptr_q[ADDR_W-1:0];
    assign WritePtr    = wptr_q[ADDR_W-1:0];
    assign OV          = ov_q;
    assign UN          = un_q;
    assign head_word   = mem[rptr_q[ADDR_W-1:0]];

    // FWFT shows the head word directly; forced to zero when empty so reset reads as 0.
    assign DataOut = FWFT ? (Empty ? '0 : head_word) : dout_q;
    assign Valid   = FWFT ? !Empty : valid_q;

    always_comb begin
        rd_ok   = Read && !Empty;
        wr_ok   = Write && (!Full || rd_ok);
        wptr_d  = wptr_q + {{ADDR_W{1'b0}}, wr_ok};
        rptr_d  = rptr_q + {{ADDR_W{1'b0}}, rd_ok};
        valid_d = rd_ok;
        dout_d  = rd_ok ? head_word : dout_q;

        // A new event in the same cycle as ClearOV takes priority over the clear.
        ov_d = ov_q;
        if (Write && !wr_ok) begin
            ov_d = 1'b1;
        end else if (ClearOV) begin
            ov_d = 1'b0;
        end

        un_d = un_q;
        if (Read && Empty) begin
            un_d = 1'b1;
        end else if (ClearOV) begin
            un_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ov_q    <= ov_d;
            un_q    <= un_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clock) begin
        if (wr_ok) begin
            mem[wptr_q[ADDR_W-1:0]] <= DataIn;
        end
    end

endmodule
